// File: rtl/huff_feed_ctrl.sv
// Huffman front-end sequencer: fetches packed stream words, slices them into
// 1-4 bit chunks gated by decoder buffer room, then drains and closes the frame.
module huff_feed_ctrl #(
  parameter int WORD_W    = 16,
  parameter int MAX_CODE  = 9,
  parameter int CNT_W     = 16,
  parameter int STALL_LIM = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  frame_bits,
  input  logic [WORD_W-1:0] s_word,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [3:0]        dec_bits,
  output logic [2:0]        dec_len,
  output logic              dec_svalid,
  input  logic [3:0]        dec_fill,
  input  logic              dec_tvalid,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  sym_count,
  output logic              err_stall
);

  localparam int WL_W = $clog2(WORD_W + 1);
  localparam int SC_W = $clog2(STALL_LIM + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_rem;
  logic [WORD_W-1:0] r_word;
  logic [WL_W-1:0]   r_wleft;
  logic [SC_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]  r_sym_count;
  logic              r_err_stall;

  logic [2:0] w_len;
  logic [4:0] w_sum;
  logic       w_room;
  logic       w_fire;
  logic [3:0] w_bits;

  always_comb begin
    w_len = 3'd4;
    if (r_wleft < WL_W'(4)) w_len = r_wleft[2:0];
    if (r_rem < CNT_W'(w_len)) w_len = r_rem[2:0];
  end

  // 5-bit sum so a nearly full buffer plus a 4-bit chunk cannot wrap to "room"
  assign w_sum  = 5'(dec_fill) + 5'(w_len);
  assign w_room = (w_sum <= 5'(MAX_CODE));
  assign w_fire = (r_state == S_ISSUE) && w_room;
  assign w_bits = 4'(r_word >> (WORD_W - int'(w_len)));

  assign s_wready   = (r_state == S_FETCH);
  assign dec_svalid = w_fire;
  assign dec_bits   = w_fire ? w_bits : 4'd0;
  assign dec_len    = w_fire ? w_len : 3'd0;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign sym_count  = r_sym_count;
  assign err_stall  = r_err_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_word      <= '0;
      r_wleft     <= '0;
      r_stall_cnt <= '0;
      r_sym_count <= '0;
      r_err_stall <= 1'b0;
    end else begin
      if (busy && dec_tvalid && !(&r_sym_count))
        r_sym_count <= r_sym_count + CNT_W'(1);

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem       <= frame_bits;
            r_sym_count <= '0;
            r_err_stall <= 1'b0;
            r_state     <= (frame_bits != '0) ? S_FETCH : S_DONE;
          end
        end
        S_FETCH: begin
          if (s_wvalid) begin
            r_word  <= s_word;
            r_wleft <= WL_W'(WORD_W);
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_room) begin
            r_word  <= r_word << w_len;
            r_wleft <= r_wleft - WL_W'(w_len);
            r_rem   <= r_rem - CNT_W'(w_len);
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          r_stall_cnt <= '0;
          if (r_rem == '0)          r_state <= S_DRAIN;
          else if (r_wleft == '0)   r_state <= S_FETCH;
          else                      r_state <= S_ISSUE;
        end
        S_DRAIN: begin
          if (dec_fill == 4'd0) begin
            r_state <= S_DONE;
          end else if (dec_tvalid) begin
            r_stall_cnt <= '0;
          end else if (r_stall_cnt == SC_W'(STALL_LIM - 1)) begin
            r_err_stall <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_stall_cnt <= r_stall_cnt + SC_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
